arb_mux_n: RTL

Parametrised, registered N-to-1 data multiplexer with request/grant arbitration. It is the successor to the fixed 16:1 8-bit select mux and sits between the ATM input channels (keypad, card reader, account store, etc.) and the shared datapath bus. It selects one requesting channel either by explicit select or by round-robin, and captures its word into an output register. The register holds the word under valid/ready back-pressure.

---
 rtl/arb_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/arb_mux_n.sv | 114 +++++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared definitions for the arb_mux_n channel multiplexer.
//   MODE_DIRECT / MODE_RR : values of the Mode input
//   slot_state_t          : output slot state (ST_EMPTY / ST_FULL)
package arb_mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational rotate-priority search.
//   req   in  N      per-channel request
//   ptr   in  SEL_W  last granted channel; search starts at ptr+1 and wraps
//   gnt   out N      one-hot grant (all zero when nothing requests)
//   idx   out SEL_W  encoded index of the granted channel
//   found out 1      some channel was granted
module rr_arbiter #(
    parameter int unsigned N     = 16,
    parameter int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    always_comb begin
        int unsigned j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        // Offset 1..N visits every channel once, ptr itself last.
        for (int unsigned off = 1; off <= N; off++) begin
            j = (32'(ptr) + off) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: registered N-to-1 data multiplexer with request/grant arbitration.
//   Clk    in  1               clock, rising edge
//   Rst    in  1               asynchronous active-high reset
//   Mode   in  1               0 = direct select, 1 = round-robin
//   Sel    in  SEL_W           channel index in direct mode
//   Req    in  CHANNELS        per-channel word valid
//   W      in  CHANNELS*WIDTH  flattened channel words, channel i at [i*WIDTH +: WIDTH]
//   Gnt    out CHANNELS        one-hot combinational grant
//   F      out WIDTH           registered output word
//   FSrc   out SEL_W           channel that produced F
//   FValid out 1               F/FSrc valid
//   FReady in  1               downstream accepts F when FValid & FReady
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 16,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Mode,
    input  logic [SEL_W-1:0]          Sel,
    input  logic [CHANNELS-1:0]       Req,
    input  logic [CHANNELS*WIDTH-1:0] W,
    output logic [CHANNELS-1:0]       Gnt,
    output logic [WIDTH-1:0]          F,
    output logic [SEL_W-1:0]          FSrc,
    output logic                      FValid,
    input  logic                      FReady
);

    slot_state_t        state_q, state_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic [SEL_W-1:0]   fsrc_q, fsrc_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic [CHANNELS-1:0] rr_gnt;
    logic [SEL_W-1:0]    rr_idx;
    logic                rr_found;

    logic                slot_free;
    logic                sel_ok;
    logic                xfer;
    logic [SEL_W-1:0]    k;

    rr_arbiter #(
        .N     (CHANNELS),
        .SEL_W (SEL_W)
    ) u_rr (
        .req   (Req),
        .ptr   (ptr_q),
        .gnt   (rr_gnt),
        .idx   (rr_idx),
        .found (rr_found)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_EMPTY;
            f_q     <= '0;
            fsrc_q  <= '0;
            ptr_q   <= SEL_W'(CHANNELS - 1);
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            fsrc_q  <= fsrc_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        fsrc_d    = fsrc_q;
        ptr_d     = ptr_q;
        Gnt       = '0;
        k         = '0;
        xfer      = 1'b0;

        slot_free = (state_q == ST_EMPTY) || FReady;
        // Sel can address beyond CHANNELS when CHANNELS is not a power of two.
        sel_ok    = 32'(Sel) < CHANNELS;

        if (!Rst && slot_free) begin
            if (Mode == MODE_DIRECT) begin
                if (sel_ok && Req[Sel]) begin
                    Gnt[Sel] = 1'b1;
                    xfer     = 1'b1;
                    k        = Sel;
                end
            end else if (rr_found) begin
                Gnt  = rr_gnt;
                xfer = 1'b1;
                k    = rr_idx;
            end
        end

        if (xfer) begin
            state_d = ST_FULL;
            f_d     = W[32'(k)*WIDTH +: WIDTH];
            fsrc_d  = k;
            ptr_d   = k;
        end else if (state_q == ST_FULL && FReady) begin
            // Word consumed, nothing new: F/FSrc keep their last value.
            state_d = ST_EMPTY;
        end
    end

    assign F      = f_q;
    assign FSrc   = fsrc_q;
    assign FValid = (state_q == ST_FULL);

endmodule
